cmp_persist: RTL

Parametrised, registered magnitude comparator with sample persistence. It compares two WIDTH-bit operands on each valid sample and produces registered raw less/equal/greater flags one cycle later. It also produces a confirmed result that changes only after PERSIST consecutive valid samples agree. It sits between the sensor/odometry counters and the rotation-timing control, where a single noisy comparison must not flip a motor decision.

---
 rtl/cmp_persist_pkg.sv | 24 ++
 rtl/cmp_persist_if.sv | 23 ++
 rtl/cmp_persist_core.sv | 51 +++++
 rtl/cmp_persist.sv | 82 ++++++++
 4 files changed

// File: rtl/cmp_persist_pkg.sv
// Shared result-code definitions for the magnitude comparator and the
// control FSMs that consume its confirmed outputs.
package cmp_pkg;

   typedef enum logic [1:0] {
      CMP_LT   = 2'd0,
      CMP_EQ   = 2'd1,
      CMP_GT   = 2'd2,
      CMP_NONE = 2'd3
   } cmp_code_t;

   // Returns {lt, eq, gt}; CMP_NONE decodes to all-zero.
   function automatic logic [2:0] cmp_onehot(input cmp_code_t c);
      logic [2:0] oh;
      case (c)
         CMP_LT:  oh = 3'b100;
         CMP_EQ:  oh = 3'b010;
         CMP_GT:  oh = 3'b001;
         default: oh = 3'b000;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/cmp_persist_if.sv
// Sample/result bundle between a counter source and cmp_persist.
interface cmp_persist_if #(
   parameter int WIDTH = 5
);
   logic             in_valid;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             l, e, g;
   logic             cl, ce, cg;
   logic             confirmed;
   logic             chg;

   modport master (
      output in_valid, a, b,
      input  out_valid, l, e, g, cl, ce, cg, confirmed, chg
   );

   modport slave (
      input  in_valid, a, b,
      output out_valid, l, e, g, cl, ce, cg, confirmed, chg
   );
endinterface

// File: rtl/cmp_persist_core.sv
// Combinational a/b -> result code, with sign handling and an optional dead
// band enabled by the macro CMP_DEADBAND_EN.
module cmp_core
   import cmp_pkg::*;
#(
   parameter int WIDTH  = 5,
   parameter int SIGNED = 0,
   parameter int BAND   = 1
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output cmp_code_t        code
);
   localparam int XW = WIDTH + 2;

   if (WIDTH < 2 || BAND < 0 || BAND >= (1 << (WIDTH - 1))) begin : g_bad_param
      $error("cmp_core: WIDTH or BAND out of range");
   end

   logic signed [XW-1:0] ax_p0, bx_p0;

   // Two guard bits keep a-b and the band offsets free of wrap.
   always_comb begin
      if (SIGNED != 0) begin
         ax_p0 = {{2{a[WIDTH-1]}}, a};
         bx_p0 = {{2{b[WIDTH-1]}}, b};
      end else begin
         ax_p0 = {2'b00, a};
         bx_p0 = {2'b00, b};
      end
   end

`ifdef CMP_DEADBAND_EN
   localparam logic signed [XW-1:0] BAND_X = XW'(BAND);
   logic signed [XW-1:0] diff_p0;

   always_comb begin
      diff_p0 = ax_p0 - bx_p0;
      if (diff_p0 > BAND_X)       code = CMP_GT;
      else if (diff_p0 < -BAND_X) code = CMP_LT;
      else                        code = CMP_EQ;
   end
`else
   always_comb begin
      if (ax_p0 < bx_p0)       code = CMP_LT;
      else if (ax_p0 == bx_p0) code = CMP_EQ;
      else                     code = CMP_GT;
   end
`endif

endmodule

// File: rtl/cmp_persist.sv
// Registered magnitude comparator with PERSIST-sample confirmation.
// Dead band is enabled by defining CMP_DEADBAND_EN.
module cmp_persist
   import cmp_pkg::*;
#(
   parameter int WIDTH   = 5,
   parameter int SIGNED  = 0,
   parameter int PERSIST = 4,
   parameter int BAND    = 1
) (
   input  logic          clk,
   input  logic          rst,
   cmp_persist_if.slave  bus
);
   localparam int PW = $clog2(PERSIST + 1);

   if (PERSIST < 1) begin : g_bad_persist
      $error("cmp_persist: PERSIST must be at least 1");
   end

   function automatic logic [PW-1:0] sat_inc(input logic [PW-1:0] c);
      if (c >= PW'(PERSIST)) return PW'(PERSIST);
      return c + PW'(1);
   endfunction

   cmp_code_t     code_p0;
   logic [PW-1:0] pcnt_nxt_p0;
   logic          confirm_p0;

   cmp_code_t     raw_code_p1;
   cmp_code_t     conf_code_p1;
   logic [PW-1:0] pcnt_p1;
   logic          vld_p1;
   logic          chg_p1;
   logic          confirmed_p1;

   cmp_core #(
      .WIDTH  (WIDTH),
      .SIGNED (SIGNED),
      .BAND   (BAND)
   ) u_core (
      .a    (bus.a),
      .b    (bus.b),
      .code (code_p0)
   );

   // Stage p0 -> p1: raw code doubles as the previous-sample code (NONE after reset).
   always_comb begin
      pcnt_nxt_p0 = (code_p0 == raw_code_p1) ? sat_inc(pcnt_p1) : PW'(1);
      confirm_p0  = (pcnt_nxt_p0 == PW'(PERSIST)) && (code_p0 != conf_code_p1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p1       <= 1'b0;
         chg_p1       <= 1'b0;
         confirmed_p1 <= 1'b0;
         raw_code_p1  <= CMP_NONE;
         conf_code_p1 <= CMP_NONE;
         pcnt_p1      <= '0;
      end else begin
         vld_p1 <= bus.in_valid;
         chg_p1 <= 1'b0;
         if (bus.in_valid) begin
            raw_code_p1 <= code_p0;
            pcnt_p1     <= pcnt_nxt_p0;
            if (confirm_p0) begin
               conf_code_p1 <= code_p0;
               confirmed_p1 <= 1'b1;
               chg_p1       <= 1'b1;
            end
         end
      end
   end

   assign bus.out_valid          = vld_p1;
   assign {bus.l, bus.e, bus.g}  = cmp_onehot(raw_code_p1);
   assign {bus.cl, bus.ce, bus.cg} = cmp_onehot(conf_code_p1);
   assign bus.confirmed          = confirmed_p1;
   assign bus.chg                = chg_p1;

endmodule
